// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports plus the RAM-side bus for ram_port_arbiter.
// slave = arbiter view, master = requesters/RAM view.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_write;
    logic [DATA_W-1:0] ram_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
               ram_address, ram_in, ram_write
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
               ram_address, ram_in, ram_write
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin sequencer for a single-port RAM: one access per two cycles,
// registered grant, RAM bus and read-data outputs.
module ram_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter int FIRST_RR = 0
) (
    input  logic               clock,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              busy_q, busy_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_in_q, ram_in_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= (FIRST_RR == 0);
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            busy_q        <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_address_q <= '0;
            ram_in_q      <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            busy_q        <= busy_d;
            ram_write_q   <= ram_write_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
        busy_d        = 1'b0;
        ram_write_d   = 1'b0;
        ram_address_d = ram_address_q;
        ram_in_d      = ram_in_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        // Under contention the port that did not win last time goes next.
        win           = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_d = ACCESS;
                    busy_d  = 1'b1;
                    last_d  = win;
                    if (win) begin
                        gnt1_d        = 1'b1;
                        ram_address_d = bus.addr1;
                        ram_in_d      = bus.wdata1;
                        ram_write_d   = bus.we1;
                    end else begin
                        gnt0_d        = 1'b1;
                        ram_address_d = bus.addr0;
                        ram_in_d      = bus.wdata0;
                        ram_write_d   = bus.we0;
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
                // last_q holds the port that owns the access in flight.
                if (!ram_write_q) begin
                    if (last_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = bus.ram_out;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = bus.ram_out;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.busy        = busy_q;
    assign bus.ram_write   = ram_write_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_in      = ram_in_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, directed vectors, corner sequences and
// random traffic against a transaction-level model.
module tb_ram_port_arbiter;
    bit clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(64)) bus ();

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(64), .FIRST_RR(0)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    logic        t_req  [2];
    logic        t_we   [2];
    logic [7:0]  t_addr [2];
    logic [63:0] t_wd   [2];

    assign bus.req0   = t_req[0];
    assign bus.req1   = t_req[1];
    assign bus.we0    = t_we[0];
    assign bus.we1    = t_we[1];
    assign bus.addr0  = t_addr[0];
    assign bus.addr1  = t_addr[1];
    assign bus.wdata0 = t_wd[0];
    assign bus.wdata1 = t_wd[1];

    // RAM: write on posedge, read data refreshed on negedge.
    logic [63:0] mem [256] = '{default: 64'h0};
    always @(posedge clock) if (bus.ram_write) mem[bus.ram_address] <= bus.ram_in;
    always @(negedge clock) bus.ram_out <= mem[bus.ram_address];

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < 2; p++) begin
            t_req[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = 8'h00; t_wd[p] = 64'h0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_gnt0"}, bus.gnt0, 1'b0);
        chk1({tag, "_gnt1"}, bus.gnt1, 1'b0);
        chk1({tag, "_rvalid0"}, bus.rvalid0, 1'b0);
        chk1({tag, "_rvalid1"}, bus.rvalid1, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_ram_write"}, bus.ram_write, 1'b0);
        chk64({tag, "_ram_address"}, 64'(bus.ram_address), 64'h0);
        chk64({tag, "_ram_in"}, bus.ram_in, 64'h0);
        chk64({tag, "_rdata0"}, bus.rdata0, 64'h0);
        chk64({tag, "_rdata1"}, bus.rdata1, 64'h0);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs [10];

    // Single isolated access: gnt the cycle after sampling, rvalid the cycle after that.
    task automatic do_single(input vec_t v);
        logic g [2];
        logic r [2];
        logic [63:0] rd;
        t_req[v.port] = 1'b1; t_we[v.port] = v.we;
        t_addr[v.port] = v.addr; t_wd[v.port] = v.wdata;
        step();
        t_req[v.port] = 1'b0;
        g[0] = bus.gnt0; g[1] = bus.gnt1;
        chk1("vec_gnt", g[v.port], 1'b1);
        chk1("vec_gnt_other", g[~v.port], 1'b0);
        chk1("vec_busy", bus.busy, 1'b1);
        chk1("vec_ram_write", bus.ram_write, v.we);
        chk64("vec_ram_address", 64'(bus.ram_address), 64'(v.addr));
        if (v.we) chk64("vec_ram_in", bus.ram_in, v.wdata);
        step();
        r[0] = bus.rvalid0; r[1] = bus.rvalid1;
        rd = v.port ? bus.rdata1 : bus.rdata0;
        chk1("vec_rvalid", r[v.port], ~v.we);
        chk1("vec_rvalid_other", r[~v.port], 1'b0);
        chk1("vec_busy_done", bus.busy, 1'b0);
        if (!v.we) chk64("vec_rdata", rd, v.rdata);
    endtask

    // Transaction-level reference for random traffic.
    bit          m_free, m_last, m_pv, m_pp;
    logic [63:0] m_pd;
    logic [63:0] ref_mem [256];
    logic        e_gnt [2];
    logic        e_rv  [2];
    logic [63:0] e_rd  [2];
    logic        e_busy, e_we;
    logic [7:0]  e_addr;
    logic [63:0] e_din;

    task automatic model_edge();
        bit w;
        e_gnt[0] = 0; e_gnt[1] = 0; e_rv[0] = 0; e_rv[1] = 0;
        e_busy = 0; e_we = 0;
        if (m_pv) begin
            e_rv[m_pp] = 1; e_rd[m_pp] = m_pd; m_pv = 0;
        end
        if (m_free && (t_req[0] || t_req[1])) begin
            if (t_req[0] && t_req[1]) w = !m_last;
            else if (t_req[0])        w = 0;
            else                      w = 1;
            e_gnt[w] = 1; e_busy = 1; e_we = t_we[w];
            e_addr = t_addr[w]; e_din = t_wd[w];
            if (t_we[w]) ref_mem[t_addr[w]] = t_wd[w];
            else begin
                m_pv = 1; m_pp = w; m_pd = ref_mem[t_addr[w]];
            end
            m_last = w; m_free = 0;
        end else begin
            m_free = 1;
        end
    endtask

    task automatic new_op(input int p);
        t_req[p]  = 1'($urandom_range(0, 1));
        t_we[p]   = 1'($urandom_range(0, 1));
        t_addr[p] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
        t_wd[p]   = {$urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ops, cyc;
        int wt [2];
        logic dg [2];

        vecs[0] = '{0, 1, 8'h10, 64'hDEAD_BEEF_0123_4567, 64'h0};
        vecs[1] = '{0, 0, 8'h10, 64'h0, 64'hDEAD_BEEF_0123_4567};
        vecs[2] = '{1, 1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
        vecs[3] = '{1, 0, 8'hFF, 64'h0, 64'h1122_3344_5566_7788};
        vecs[4] = '{0, 0, 8'hFF, 64'h0, 64'h1122_3344_5566_7788};
        vecs[5] = '{1, 1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[6] = '{0, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{0, 1, 8'h30, 64'h3030_3030_3030_3030, 64'h0};
        vecs[8] = '{1, 1, 8'h31, 64'h3131_3131_3131_3131, 64'h0};
        vecs[9] = '{1, 0, 8'h10, 64'h0, 64'hDEAD_BEEF_0123_4567};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 10; i++) do_single(vecs[i]);

        // Both ports reading continuously from reset: 0,1,0,1 alternation.
        do_reset();
        t_req[0] = 1; t_addr[0] = 8'h30;
        t_req[1] = 1; t_addr[1] = 8'h31;
        for (int k = 0; k < 8; k++) begin
            step();
            chk1("alt_gnt0", bus.gnt0, k % 4 == 0);
            chk1("alt_rvalid0", bus.rvalid0, k % 4 == 1);
            chk1("alt_gnt1", bus.gnt1, k % 4 == 2);
            chk1("alt_rvalid1", bus.rvalid1, k % 4 == 3);
            if (k % 4 == 1) chk64("alt_rdata0", bus.rdata0, 64'h3030_3030_3030_3030);
            if (k % 4 == 3) chk64("alt_rdata1", bus.rdata1, 64'h3131_3131_3131_3131);
        end
        clear_reqs();
        step();

        // Read-after-write on 8'hFF with port 1 waiting.
        do_reset();
        t_req[0] = 1; t_we[0] = 1; t_addr[0] = 8'hFF; t_wd[0] = 64'h1;
        t_req[1] = 1; t_we[1] = 0; t_addr[1] = 8'hFF;
        step();
        chk1("raw_gnt0", bus.gnt0, 1'b1);
        chk1("raw_gnt1_wait", bus.gnt1, 1'b0);
        chk1("raw_ram_write", bus.ram_write, 1'b1);
        t_req[0] = 0;
        step();
        chk1("raw_no_rvalid0", bus.rvalid0, 1'b0);
        chk1("raw_no_rvalid1", bus.rvalid1, 1'b0);
        step();
        chk1("raw_gnt1", bus.gnt1, 1'b1);
        t_req[1] = 0;
        step();
        chk1("raw_rvalid1", bus.rvalid1, 1'b1);
        chk64("raw_rdata1", bus.rdata1, 64'h1);

        // Reset during the ACCESS cycle of a write.
        t_req[0] = 1; t_we[0] = 1; t_addr[0] = 8'h20; t_wd[0] = 64'hA5;
        step();
        chk1("rstacc_gnt0", bus.gnt0, 1'b1);
        chk1("rstacc_ram_write", bus.ram_write, 1'b1);
        reset = 1; t_req[0] = 0;
        step();
        chk_all_zero("rstacc");
        chk64("rstacc_mem20", mem[8'h20], 64'hA5);
        reset = 0;
        step();
        chk1("rstacc_no_rvalid0", bus.rvalid0, 1'b0);
        chk1("rstacc_no_gnt0", bus.gnt0, 1'b0);

        // req1 raised only while busy, then withdrawn: no access.
        t_req[0] = 1; t_we[0] = 0; t_addr[0] = 8'h10;
        step();
        chk1("wd_gnt0", bus.gnt0, 1'b1);
        t_req[0] = 0;
        t_req[1] = 1; t_we[1] = 1; t_addr[1] = 8'h40; t_wd[1] = 64'h77;
        step();
        chk1("wd_rvalid0", bus.rvalid0, 1'b1);
        chk64("wd_rdata0", bus.rdata0, 64'hDEAD_BEEF_0123_4567);
        chk1("wd_gnt1_a", bus.gnt1, 1'b0);
        t_req[1] = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk1("wd_gnt1", bus.gnt1, 1'b0);
            chk1("wd_ram_write", bus.ram_write, 1'b0);
            chk1("wd_busy", bus.busy, 1'b0);
        end
        chk64("wd_mem40", mem[8'h40], 64'h0);

        // Random mixed traffic.
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        m_free = 1; m_last = 1; m_pv = 0; m_pp = 0; m_pd = 0;
        e_rd[0] = 0; e_rd[1] = 0; e_addr = 0; e_din = 0;
        wt[0] = 0; wt[1] = 0;
        ops = 0; cyc = 0;
        while (ops < 1000 && cyc < 20000) begin
            model_edge();
            step();
            cyc++;
            chk1("rnd_gnt0", bus.gnt0, e_gnt[0]);
            chk1("rnd_gnt1", bus.gnt1, e_gnt[1]);
            chk1("rnd_rvalid0", bus.rvalid0, e_rv[0]);
            chk1("rnd_rvalid1", bus.rvalid1, e_rv[1]);
            chk1("rnd_busy", bus.busy, e_busy);
            chk1("rnd_ram_write", bus.ram_write, e_we);
            chk64("rnd_ram_address", 64'(bus.ram_address), 64'(e_addr));
            chk64("rnd_ram_in", bus.ram_in, e_din);
            chk64("rnd_rdata0", bus.rdata0, e_rd[0]);
            chk64("rnd_rdata1", bus.rdata1, e_rd[1]);
            chk1("rnd_gnt_onehot", bus.gnt0 & bus.gnt1, 1'b0);
            chk1("rnd_rvalid_onehot", bus.rvalid0 & bus.rvalid1, 1'b0);
            chk1("rnd_gnt_rvalid_excl", (bus.gnt0 | bus.gnt1) & (bus.rvalid0 | bus.rvalid1), 1'b0);
            dg[0] = bus.gnt0; dg[1] = bus.gnt1;
            for (int p = 0; p < 2; p++) begin
                if (t_req[p] && !dg[p]) wt[p]++;
                else wt[p] = 0;
                chk1("rnd_starve", wt[p] > 4, 1'b0);
            end
            for (int p = 0; p < 2; p++) begin
                if (e_gnt[p]) begin
                    ops++;
                    new_op(p);
                end else if (t_req[p]) begin
                    if ($urandom_range(0, 31) == 0) t_req[p] = 0;
                end else if ($urandom_range(0, 1) == 1) begin
                    new_op(p);
                    t_req[p] = 1;
                end
            end
        end
        chk1("rnd_ops_done", ops >= 1000, 1'b1);
        clear_reqs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
